// File: rtl/store_trace_pkg.sv
// ============================================================================
// Module   : store_trace_pkg
// Brief    : Shared types for the store trace monitor and its trace FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_trace_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } monitor_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
    } store_entry_t;

    localparam logic [15:0] c_STORE_COUNT_MAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// Module   : trace_fifo
// Brief    : First-word-fall-through FIFO of store entries with a registered head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_fifo
    import store_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  store_entry_t push_entry,
    output store_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int c_AW = $clog2(DEPTH);

    store_entry_t   r_mem [DEPTH];
    store_entry_t   r_head;
    store_entry_t   w_head_next;
    logic [c_AW:0]  r_wr_ptr;
    logic [c_AW:0]  r_rd_ptr;
    logic [c_AW:0]  w_wr_next;
    logic [c_AW:0]  w_rd_next;
    logic           w_do_push;
    logic           w_do_pop;

    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign head  = r_head;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;
    assign w_wr_next = r_wr_ptr + {{c_AW{1'b0}}, w_do_push};
    assign w_rd_next = r_rd_ptr + {{c_AW{1'b0}}, w_do_pop};

    // Head keeps its last value when the FIFO drains empty.
    always_comb begin
        w_head_next = r_head;
        if (w_rd_next != w_wr_next) begin
            if (w_rd_next == r_wr_ptr) begin
                w_head_next = push_entry;
            end else begin
                w_head_next = r_mem[w_rd_next[c_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_head   <= w_head_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_trace_monitor.sv
// ============================================================================
// Module   : store_trace_monitor
// Brief    : Buffers core stores in a trace FIFO and decides PASS/FAIL/TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_trace_monitor
    import store_trace_pkg::*;
#(
    parameter int          DEPTH           = 16,
    parameter logic [31:0] PASS_ADDRESS    = 32'd100,
    parameter logic [31:0] PASS_DATA       = 32'd7,
    parameter logic [31:0] SCRATCH_ADDRESS = 32'd96,
    parameter int          TIMEOUT_CYCLES  = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_write_enable,
    input  logic [31:0] data_memory_address,
    input  logic [31:0] write_data,
    input  logic        trace_ready,
    output logic        trace_valid,
    output logic [31:0] trace_address,
    output logic [31:0] trace_data,
    output logic [1:0]  status,
    output logic        done,
    output logic        overflow,
    output logic [15:0] store_count
);

    monitor_state_t r_state;
    monitor_state_t w_state_next;
    logic [31:0]    r_timeout_count;
    logic [31:0]    w_timeout_next;
    logic           r_done;
    logic           r_overflow;
    logic [15:0]    r_store_count;
    logic           w_store_in_run;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    store_entry_t   w_push_entry;
    store_entry_t   w_head;

    assign w_store_in_run = memory_write_enable && (r_state == RUN);
    assign w_pop          = !w_empty && trace_ready;
    assign w_push_entry   = '{address: data_memory_address, data: write_data};

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (w_store_in_run),
        .pop        (w_pop),
        .push_entry (w_push_entry),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty)
    );

    // A store in the expiry cycle takes precedence over the timeout.
    always_comb begin
        w_state_next   = r_state;
        w_timeout_next = r_timeout_count;
        if (r_state == RUN) begin
            if (memory_write_enable) begin
                w_timeout_next = '0;
                if (data_memory_address == PASS_ADDRESS) begin
                    w_state_next = (write_data == PASS_DATA) ? PASS : FAIL;
                end else if (data_memory_address != SCRATCH_ADDRESS) begin
                    w_state_next = FAIL;
                end
            end else begin
                w_timeout_next = r_timeout_count + 32'd1;
                if ((TIMEOUT_CYCLES != 0) && (w_timeout_next == 32'(TIMEOUT_CYCLES))) begin
                    w_state_next = TIMEOUT;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= RUN;
            r_timeout_count <= '0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_timeout_count <= w_timeout_next;
            r_done          <= (w_state_next != RUN);
        end
    end

    // Dropped stores are still counted; overflow only records the loss.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_store_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_store_in_run && (r_store_count != c_STORE_COUNT_MAX)) begin
                r_store_count <= r_store_count + 16'd1;
            end
            if (w_store_in_run && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign trace_valid   = !w_empty;
    assign trace_address = w_head.address;
    assign trace_data    = w_head.data;
    assign status        = r_state;
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign store_count   = r_store_count;

endmodule

`default_nettype wire
